// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow-out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: computes r1 - r2 - bi LSB-first, one bit per
// clock, with valid/ready handshakes on both the operand and result sides.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] r1,
  input  logic [WIDTH-1:0] r2,
  input  logic             bi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             borrow
);

  localparam int              CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, r_q, r_d;
  logic              br_q, br_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              borrow_q, borrow_d;
  logic              cell_d, cell_bout;

  full_subtractor u_cell (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (br_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)          state_d = SHIFT;
      SHIFT:   if (cnt_q == CNT_LAST) state_d = DONE;
      DONE:    if (out_ready)         state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  always_comb begin
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    r_d      = r_q;
    br_d     = br_q;
    result_d = result_q;
    borrow_d = borrow_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d   = r1;
          b_d   = r2;
          br_d  = bi;
          cnt_d = '0;
        end
      end
      SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        r_d   = {cell_d, r_q[WIDTH-1:1]};
        br_d  = cell_bout;
        cnt_d = cnt_q + 1'b1;
        // Publish only on the final bit so result/borrow never show partial sums.
        if (cnt_q == CNT_LAST) begin
          result_d = {cell_d, r_q[WIDTH-1:1]};
          borrow_d = cell_bout;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      br_q     <= 1'b0;
      result_q <= '0;
      borrow_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      r_q      <= r_d;
      br_q     <= br_d;
      result_q <= result_d;
      borrow_q <= borrow_d;
    end
  end

  assign result = result_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed table, handshake corner
// sequences and a randomized scoreboard against an arithmetic reference.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] r1, r2;
  logic         bi;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         borrow;

  int n_vec = 0;
  int n_err = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .r1        (r1),
    .r2        (r2),
    .bi        (bi),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .borrow    (borrow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic [W-1:0] exp_res;
    logic         exp_bo;
  } vec_t;

  typedef struct {
    logic [W-1:0] res;
    logic         bo;
  } exp_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer subtraction, wrapped to W bits.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int   diff;
    exp_t e;
    diff  = int'(a) - int'(b) - int'(c);
    e.bo  = (diff < 0);
    e.res = W'((diff + (1 << (W + 1))) % (1 << W));
    return e;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Issue one op, wait for the result, hold it for 'stalls' cycles, then accept.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input int stalls, output logic [W-1:0] res, output logic bo,
                        output int lat);
    int g;
    logic [W-1:0] held;
    @(negedge clk);
    g = 0;
    while (!in_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    r1 = a; r2 = b; bi = c; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res  = result;
    bo   = borrow;
    held = result;
    for (int i = 0; i < stalls; i++) begin
      @(posedge clk);
      #1;
      check("stall_out_valid", out_valid, 1);
      check("stall_result", result, held);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("release_out_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
  endtask

  initial begin
    vec_t         tbl[9];
    logic [W-1:0] res;
    logic         bo;
    int           lat;
    exp_t         q[$];
    exp_t         e;
    int           sent, got, cyc, seen;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    r1 = '0; r2 = '0; bi = 1'b0;
    do_reset();
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_result", result, 0);
    check("reset_borrow", borrow, 0);

    tbl[0] = '{4'd9,  4'd3,  1'b0, 4'h6, 1'b0};
    tbl[1] = '{4'd3,  4'd9,  1'b0, 4'hA, 1'b1};
    tbl[2] = '{4'd0,  4'd0,  1'b1, 4'hF, 1'b1};
    tbl[3] = '{4'd15, 4'd15, 1'b1, 4'hF, 1'b1};
    tbl[4] = '{4'd5,  4'd2,  1'b0, 4'h3, 1'b0};
    tbl[5] = '{4'd15, 4'd0,  1'b0, 4'hF, 1'b0};
    tbl[6] = '{4'd8,  4'd7,  1'b1, 4'h0, 1'b0};
    tbl[7] = '{4'd0,  4'd15, 1'b0, 4'h1, 1'b1};
    tbl[8] = '{4'd7,  4'd7,  1'b0, 4'h0, 1'b0};

    // out_valid first visible W edges after the accepting edge.
    foreach (tbl[i]) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].c, 0, res, bo, lat);
      check($sformatf("tbl%0d_latency", i), lat, W);
      check($sformatf("tbl%0d_result", i), res, tbl[i].exp_res);
      check($sformatf("tbl%0d_borrow", i), bo, tbl[i].exp_bo);
    end

    // Backpressure: three stalled cycles in DONE.
    run_op(4'd12, 4'd5, 1'b0, 3, res, bo, lat);
    check("bp_result", res, 4'd7);
    check("bp_borrow", bo, 1'b0);

    // in_valid pulsed mid-SHIFT must be ignored.
    @(negedge clk);
    r1 = 4'd9; r2 = 4'd3; bi = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("busy_in_ready", in_ready, 0);
    r1 = 4'd7; r2 = 4'd1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("ignore_latency", lat, W);
    check("ignore_result", result, 4'd6);
    check("ignore_borrow", borrow, 1'b0);
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    seen = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("ignore_no_second", seen, 0);

    // Reset during the second SHIFT cycle aborts the op.
    @(negedge clk);
    r1 = 4'd14; r2 = 4'd1; bi = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_result", result, 0);
    check("abort_borrow", borrow, 0);
    run_op(4'd5, 4'd2, 1'b0, 0, res, bo, lat);
    check("post_abort_result", res, 4'd3);
    check("post_abort_borrow", bo, 1'b0);

    // Random scoreboard with random valid/ready on both sides.
    sent = 0; got = 0; cyc = 0;
    while (got < 1000 && cyc < 60000) begin
      @(negedge clk);
      in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
      r1        = W'($urandom);
      r2        = W'($urandom);
      bi        = 1'($urandom);
      out_ready = ($urandom_range(0, 1) == 1);
      if (in_valid && in_ready) begin
        q.push_back(model(r1, r2, bi));
        sent++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("rand_unexpected_result", 1, 0);
        end else begin
          e = q.pop_front();
          check("rand_result", result, e.res);
          check("rand_borrow", borrow, e.bo);
        end
        got++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("rand_completed", got, 1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
